// File: rtl/nn_mul_share_arb_pkg.sv
// Shared defaults, tag-width helper and request/response record types for the
// time-shared multiplier arbiter.
package nn_mul_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 44;
  localparam int B_W_DEF   = 6;
  localparam int P_W_DEF   = A_W_DEF + B_W_DEF;
  localparam int CNT_W_DEF = 32;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);

  typedef struct packed {
    logic [A_W_DEF-1:0]  a;
    logic [B_W_DEF-1:0]  b;
    logic [ID_W_DEF-1:0] id;
  } req_t;

  typedef struct packed {
    logic [P_W_DEF-1:0]  data;
    logic [ID_W_DEF-1:0] id;
  } rsp_t;

endpackage

// File: rtl/nn_mul_share_arb_if.sv
// Request/response bundle between the requesters, the response consumer and
// the arbiter. The master side drives requests and consumes responses.
interface nn_mul_share_arb_if
  import nn_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int P_W   = P_W_DEF
) ();

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [P_W-1:0]       rsp_data;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/nn_mul_share_arb_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// scanning upward with wrap; the pointer moves past the winner on advance.
module nn_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic             adv,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;
  logic [N_REQ-1:0] rot_req;
  logic [ID_W-1:0]  rot_idx [N_REQ];
  logic             found;
  logic [ID_W-1:0]  sel;

  // Modulo-N_REQ add; both operands are already below N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] x,
                                               input logic [ID_W-1:0] y);
    logic [ID_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (ID_W+1)'(N_REQ)) begin
      s = s - (ID_W+1)'(N_REQ);
    end
    return s[ID_W-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_idx[gi] = wrap_add(ptr_reg, ID_W'(gi));
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot_req[i]) begin
        found = 1'b1;
        sel   = rot_idx[i];
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = sel;
    if (en && found) begin
      gnt[sel] = 1'b1;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (adv) begin
      ptr_next = wrap_add(sel, ID_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/nn_mul_share_arb.sv
// Time-shares one external combinational multiplier among N_REQ requesters:
// round-robin grant into an operand stage, then a tagged result register.
module nn_mul_share_arb
  import nn_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_width(N_REQ),
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int P_W   = P_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  nn_mul_share_arb_if.slave bus,
  output logic [A_W-1:0]   mul_din0,
  output logic [B_W-1:0]   mul_din1,
  input  logic [P_W-1:0]   mul_dout,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             idle
);

  generate
    if (P_W != A_W + B_W) begin : g_bad_pw
      $error("nn_mul_share_arb: P_W must equal A_W + B_W");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("nn_mul_share_arb: N_REQ must be in 2..8");
    end
    if (ID_W != id_width(N_REQ)) begin : g_bad_idw
      $error("nn_mul_share_arb: ID_W must equal clog2(N_REQ)");
    end
  endgenerate

  logic [A_W-1:0]   op_a [N_REQ];
  logic [B_W-1:0]   op_b [N_REQ];

  logic             s1_v_reg;
  logic [A_W-1:0]   s1_a_reg;
  logic [B_W-1:0]   s1_b_reg;
  logic [ID_W-1:0]  s1_id_reg;

  logic             rsp_valid_reg;
  logic [P_W-1:0]   rsp_data_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [CNT_W-1:0] txn_cnt_reg;

  logic             s2_adv;
  logic             s1_adv;
  logic             arb_en;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             take;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_a[gi] = bus.req_a[gi*A_W +: A_W];
      assign op_b[gi] = bus.req_b[gi*B_W +: B_W];
    end
  endgenerate

  assign s2_adv = !rsp_valid_reg || bus.rsp_ready;
  assign s1_adv = !s1_v_reg || s2_adv;
  // Gating with reset keeps req_ready low while ap_rst_n is asserted.
  assign arb_en = s1_adv && ap_rst_n;
  assign take   = |gnt;

  nn_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .req     (bus.req_valid),
    .en      (arb_en),
    .adv     (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;

  // Operand stage; operands hold when no grant so the multiplier inputs stay quiet.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_v_reg  <= 1'b0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
      s1_id_reg <= '0;
    end else if (s1_adv) begin
      s1_v_reg <= take;
      if (take) begin
        s1_a_reg  <= op_a[gnt_idx];
        s1_b_reg  <= op_b[gnt_idx];
        s1_id_reg <= gnt_idx;
      end
    end
  end

  assign mul_din0 = s1_a_reg;
  assign mul_din1 = s1_b_reg;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else if (s2_adv) begin
      rsp_valid_reg <= s1_v_reg;
      if (s1_v_reg) begin
        rsp_data_reg <= mul_dout;
        rsp_id_reg   <= s1_id_reg;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      txn_cnt_reg <= '0;
    end else if (rsp_valid_reg && bus.rsp_ready) begin
      txn_cnt_reg <= txn_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign txn_cnt       = txn_cnt_reg;
  assign idle          = !(|bus.req_valid) && !s1_v_reg && !rsp_valid_reg;

endmodule

// File: doc/nn_mul_share_arb.md
Name: nn_mul_share_arb

Overview:
- Time-shares one combinational 44x6 unsigned multiplier instance (NUM_STAGE=0) among N_REQ requesters.
- Typical requesters are the AlexNet layer address generators (index x stride).
- Round-robin arbitration with valid/ready handshakes per requester, and a 2-stage operand/result pipeline with backpressure.
- Returns a tagged product on a single shared response channel.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester tag, equals clog2(N_REQ)
A_W, 44, operand A width (unsigned)
B_W, 6, operand B width (unsigned)
P_W, 50, product width; must equal A_W+B_W, elaboration error otherwise
CNT_W, 32, transaction counter width

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
req_a  in  N_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
req_b  in  N_REQ*B_W  packed operand B, requester i at [i*B_W +: B_W]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  P_W  product
rsp_id  out  ID_W  index of the requester that issued the product
mul_din0  out  A_W  to shared multiplier din0
mul_din1  out  B_W  to shared multiplier din1
mul_dout  in  P_W  from shared multiplier dout
txn_cnt  out  CNT_W  count of completed responses, wraps
idle  out  1  high when no valid request and both stages empty

Behaviour:
- Clock and reset: one clock, ap_clk; reset ap_rst_n is synchronous, active-low.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, S1 valid/operands/id=0, rr pointer=0, txn_cnt=0, idle=1. req_ready is forced to 0 while ap_rst_n=0.
- Stage S1 holds s1_v, s1_a, s1_b and s1_id. mul_din0=s1_a and mul_din1=s1_b at all times, including when s1_v=0.
- Stage S2 is the output register: rsp_valid, rsp_data and rsp_id.
- Advance logic: s2_adv = !rsp_valid | rsp_ready; s1_adv = !s1_v | s2_adv.
- Grant: when s1_adv=1 and any req_valid, grant the first valid requester at or after rr pointer, in index order with wrap. req_ready[g]=1 combinationally and all other bits are 0. When s1_adv=0, req_ready is all 0.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On a handshake at edge k, S1 loads req_a[g], req_b[g] and g, and sets s1_v=1. The pointer becomes (g+1) mod N_REQ. The pointer is unchanged when nothing is granted.
- When s1_adv=1 and no grant occurs, s1_v is cleared and the operand registers hold their values.
- When s2_adv=1, S2 loads rsp_valid=s1_v, rsp_data=mul_dout and rsp_id=s1_id. rsp_data/rsp_id are updated only when s1_v=1.
- When s2_adv=0, S2 holds. Output stays stable while rsp_valid=1 and rsp_ready=0.
- Latency: handshake in cycle c gives rsp_valid in cycle c+2. Throughput is 1 result/cycle with rsp_ready held high.
- Arithmetic: unsigned, exact; P_W=A_W+B_W, so no truncation or overflow.
- txn_cnt increments on every rsp_valid & rsp_ready and wraps modulo 2^CNT_W.
- A simultaneous response pop and new grant are both taken in the same cycle with no bubble.
- Reset mid-operation discards S1/S2 contents with no response emitted. The pointer returns to 0.

Decomposition:
- Package nn_mul_pkg holds the A_W/B_W/P_W defaults, ID_W derivation helper, and req/rsp struct typedefs (a, b, id; data, id).
- Sub-module nn_rr_arbiter: N_REQ-wide round-robin, with inputs req, en and pointer-advance, and outputs one-hot gnt and gnt_idx. The pointer register lives inside it, reset to 0.
- The multiplier stays external so the generated instance is reused unchanged.

Test Plan:
- Single request: requester 2, a=1000, b=7 -> req_ready[2]=1 in cycle c; rsp_valid in c+2 with rsp_data=7000, rsp_id=2; txn_cnt=1.
- All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; rsp_id sequence matches; one result per cycle.
- Max operands: a=0xFFFFFFFFFFF, b=63 -> rsp_data=0x3EFFFFFFFFFC1 (no truncation).
- Backpressure: rsp_ready=0 for 5 cycles with traffic -> rsp_data/rsp_id stable; S1 fills; req_ready all 0; after release, no loss or duplication and order is preserved.
- Fairness: requester 0 always valid, requester 3 valid once -> requester 3 is granted within 4 cycles; pointer moves to 0 after its grant.
- Reset mid-stream: ap_rst_n low for 1 cycle with S1 and S2 full -> next cycle rsp_valid=0, txn_cnt=0, idle=1 once requests drop; the first grant after reset goes to the lowest valid index.
